// File: rtl/game_move_controller_if.sv
// Move request handshake between the keypad decoder and the move controller.
// master drives the request, slave reports readiness.
interface game_move_controller_if;
  logic       move_valid;
  logic [3:0] move_dir;
  logic       move_ready;

  modport master (
    output move_valid,
    output move_dir,
    input  move_ready
  );

  modport slave (
    input  move_valid,
    input  move_dir,
    output move_ready
  );
endinterface

// File: rtl/game_move_controller.sv
// Sequential front end for the 4x4 merge block: owns board and score,
// sequences move, tile spawn and win/game-over evaluation.
module game_move_controller #(
  parameter logic [11:0] WIN_TILE  = 12'd2048,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              load_en,
  input  logic [15:0][11:0] load_board,
  game_move_controller_if.slave mv,
  output logic [3:0]        mm_direction,
  output logic [15:0][11:0] mm_board_in,
  input  logic [15:0][11:0] mm_board_out,
  input  logic [19:0]       mm_score_update,
  output logic [15:0][11:0] board,
  output logic [19:0]       score,
  output logic              move_done,
  output logic              moved,
  output logic              game_won,
  output logic              game_over
);

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    SPAWN,
    CHECK
  } state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic        changed;
  logic        from_move;
  logic        second;

  logic [15:0] lfsr_next;
  logic        xfer;
  logic [20:0] sum;
  logic        spawn_hit;
  logic [3:0]  spawn_idx;
  logic [3:0]  cand;
  logic        any_zero;
  logic        any_pair;
  logic        any_win;

  assign mm_board_in = board;

  assign mv.move_ready = (state == IDLE) && !game_over
                       && !start && !load_en;

  assign xfer = mv.move_valid && mv.move_ready
              && $onehot(mv.move_dir);

  assign lfsr_next = {lfsr[14:0],
                      lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  assign sum = {1'b0, score} + {1'b0, mm_score_update};

  // first empty cell, scanning upward from the LFSR start index with wrap
  always_comb begin
    spawn_hit = 1'b0;
    spawn_idx = '0;
    cand      = '0;
    for (int i = 0; i < 16; i++) begin
      cand = lfsr[3:0] + 4'(i);
      if (!spawn_hit && board[cand] == '0) begin
        spawn_hit = 1'b1;
        spawn_idx = cand;
      end
    end
  end

  always_comb begin
    any_zero = 1'b0;
    any_pair = 1'b0;
    any_win  = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (board[r*4+c] == '0)
          any_zero = 1'b1;
        if (board[r*4+c] >= WIN_TILE)
          any_win = 1'b1;
        if (c < 3 && board[r*4+c] == board[r*4+c+1])
          any_pair = 1'b1;
        if (r < 3 && board[r*4+c] == board[r*4+c+4])
          any_pair = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      board        <= '0;
      score        <= '0;
      lfsr         <= LFSR_SEED;
      mm_direction <= '0;
      move_done    <= 1'b0;
      moved        <= 1'b0;
      game_won     <= 1'b0;
      game_over    <= 1'b0;
      changed      <= 1'b0;
      from_move    <= 1'b0;
      second       <= 1'b0;
    end else begin
      lfsr      <= lfsr_next;
      move_done <= 1'b0;
      if (start) begin
        state        <= SPAWN;
        board        <= '0;
        score        <= '0;
        lfsr         <= LFSR_SEED;
        mm_direction <= '0;
        moved        <= 1'b0;
        game_won     <= 1'b0;
        game_over    <= 1'b0;
        changed      <= 1'b0;
        from_move    <= 1'b0;
        second       <= 1'b1;
      end else if (load_en && state == IDLE) begin
        state     <= CHECK;
        board     <= load_board;
        score     <= '0;
        moved     <= 1'b0;
        game_won  <= 1'b0;
        game_over <= 1'b0;
        from_move <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (xfer) begin
              mm_direction <= mv.move_dir;
              state        <= MOVE;
            end
          end
          MOVE: begin
            mm_direction <= '0;
            from_move    <= 1'b1;
            if (mm_board_out != board) begin
              board   <= mm_board_out;
              score   <= sum[20] ? 20'hFFFFF : sum[19:0];
              changed <= 1'b1;
              state   <= SPAWN;
            end else begin
              changed <= 1'b0;
              state   <= CHECK;
            end
          end
          SPAWN: begin
            if (spawn_hit)
              board[spawn_idx] <= (lfsr[7:4] == 4'd0) ? 12'd4 : 12'd2;
            // a new game places two tiles back to back
            if (second) begin
              second <= 1'b0;
              state  <= SPAWN;
            end else begin
              state <= CHECK;
            end
          end
          CHECK: begin
            if (any_win)
              game_won <= 1'b1;
            if (!any_zero && !any_pair)
              game_over <= 1'b1;
            if (from_move) begin
              move_done <= 1'b1;
              moved     <= changed;
            end
            from_move <= 1'b0;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_move_controller.sv
// Bench for game_move_controller with a behavioural merge block
// and a scoreboard of expected move completions.
module tb_game_move_controller;

  typedef logic [15:0][11:0] board_t;

  typedef struct {
    board_t      ld;
    logic [3:0]  dir;
    int          lat;
    logic        mvd;
    logic [19:0] sc;
    logic        won;
    int          idx;
    logic [11:0] val;
    int          cnt;
  } vec_t;

  typedef struct {
    int          acc;
    int          lat;
    logic        mvd;
    logic [19:0] sc;
    logic        won;
    int          idx;
    logic [11:0] val;
    int          cnt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        load_en;
  board_t      load_board;
  logic [3:0]  mm_direction;
  board_t      mm_board_in;
  board_t      mm_board_out;
  logic [19:0] mm_score_update;
  board_t      board;
  logic [19:0] score;
  logic        move_done;
  logic        moved;
  logic        game_won;
  logic        game_over;

  logic [19:0] model_sc;
  logic        ovr_en;
  logic [19:0] ovr_score;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_seen = 0;
  exp_t sb[$];

  game_move_controller_if mif ();

  game_move_controller dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .load_en         (load_en),
    .load_board      (load_board),
    .mv              (mif),
    .mm_direction    (mm_direction),
    .mm_board_in     (mm_board_in),
    .mm_board_out    (mm_board_out),
    .mm_score_update (mm_score_update),
    .board           (board),
    .score           (score),
    .move_done       (move_done),
    .moved           (moved),
    .game_won        (game_won),
    .game_over       (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference slide/merge toward the edge named by the one-hot direction
  function automatic void do_merge(input board_t b, input logic [3:0] d,
                                   output board_t o, output logic [19:0] s);
    int idx[4];
    logic [11:0] v[4];
    logic [11:0] pk[4];
    int n;
    int m;
    int j;
    o = b;
    s = '0;
    if (!$onehot(d))
      return;
    for (int k = 0; k < 4; k++) begin
      for (int q = 0; q < 4; q++) begin
        case (d)
          4'b0001: idx[q] = q * 4 + k;
          4'b0010: idx[q] = (3 - q) * 4 + k;
          4'b0100: idx[q] = k * 4 + q;
          default: idx[q] = k * 4 + 3 - q;
        endcase
        v[q]  = '0;
        pk[q] = '0;
      end
      n = 0;
      for (int q = 0; q < 4; q++) begin
        if (b[idx[q]] != '0) begin
          v[n] = b[idx[q]];
          n++;
        end
      end
      m = 0;
      j = 0;
      while (j < n) begin
        if (j + 1 < n && v[j] == v[j+1]) begin
          pk[m] = v[j] << 1;
          s = s + 20'(pk[m]);
          j = j + 2;
        end else begin
          pk[m] = v[j];
          j = j + 1;
        end
        m++;
      end
      for (int q = 0; q < 4; q++)
        o[idx[q]] = pk[q];
    end
  endfunction

  always_comb begin
    mm_board_out = '0;
    model_sc     = '0;
    do_merge(mm_board_in, mm_direction, mm_board_out, model_sc);
  end

  assign mm_score_update = ovr_en ? ovr_score : model_sc;

  function automatic int nz(input board_t b);
    int c = 0;
    for (int i = 0; i < 16; i++)
      if (b[i] != '0) c++;
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // completion monitor: pops the scoreboard on each move_done pulse
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (move_done) begin
        done_seen++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_move_done: got 1 expected 0");
        end else begin
          e = sb.pop_front();
          chk("latency", cyc - e.acc + 1, e.lat);
          chk("moved", moved, e.mvd);
          chk("score", score, e.sc);
          chk("game_won", game_won, e.won);
          if (e.idx >= 0)
            chk("tile", board[e.idx], e.val);
          if (e.cnt >= 0)
            chk("tile_count", nz(board), e.cnt);
        end
      end
    end
  end

  task automatic do_load(input board_t b);
    @(negedge clk);
    load_en    = 1'b1;
    load_board = b;
    @(negedge clk);
    load_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_move(input logic [3:0] d, input int lat,
                          input logic mvd, input logic [19:0] sc,
                          input logic won, input int idx,
                          input logic [11:0] val, input int cnt);
    exp_t e;
    @(negedge clk);
    chk("ready_before_move", mif.move_ready, 1);
    mif.move_valid = 1'b1;
    mif.move_dir   = d;
    e = '{cyc + 1, lat, mvd, sc, won, idx, val, cnt};
    sb.push_back(e);
    @(negedge clk);
    mif.move_valid = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++)
      @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL move_timeout: got pending %0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vt[6];
    board_t b;
    board_t k;
    int     d0;
    int     ok;

    b = '0;
    vt[0] = '{b, 4'b0100, 3, 1'b0, 20'd0, 1'b0, 0, 12'd0, 0};
    b[0] = 12'd2; b[1] = 12'd2; b[2] = 12'd4; b[3] = 12'd4;
    b[4] = 12'd2; b[5] = 12'd2; b[6] = 12'd4; b[7] = 12'd4;
    vt[1] = '{b, 4'b0001, 4, 1'b1, 20'd24, 1'b0, 2, 12'd8, 5};
    b = '0;
    b[0] = 12'd1024; b[1] = 12'd1024;
    vt[2] = '{b, 4'b0100, 4, 1'b1, 20'd2048, 1'b1, 0, 12'd2048, 2};
    b = '0;
    b[0] = 12'd2; b[3] = 12'd2;
    vt[3] = '{b, 4'b1000, 4, 1'b1, 20'd4, 1'b0, 3, 12'd4, 2};
    b = '0;
    b[0] = 12'd2; b[4] = 12'd2; b[8] = 12'd2; b[12] = 12'd2;
    vt[4] = '{b, 4'b0010, 4, 1'b1, 20'd8, 1'b0, 12, 12'd4, 3};
    b = '0;
    b[0] = 12'd4; b[1] = 12'd8; b[2] = 12'd16; b[3] = 12'd32;
    vt[5] = '{b, 4'b0100, 3, 1'b0, 20'd0, 1'b0, 3, 12'd32, 4};

    rst_n          = 1'b0;
    start          = 1'b0;
    load_en        = 1'b0;
    load_board     = '0;
    mif.move_valid = 1'b0;
    mif.move_dir   = '0;
    ovr_en         = 1'b0;
    ovr_score      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tiles", nz(board), 0);
    chk("rst_score", score, 0);
    chk("rst_ready", mif.move_ready, 1);
    chk("rst_won", game_won, 0);
    chk("rst_over", game_over, 0);
    chk("rst_done", move_done, 0);
    chk("rst_dir", mm_direction, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      do_load(vt[i].ld);
      run_move(vt[i].dir, vt[i].lat, vt[i].mvd, vt[i].sc, vt[i].won,
               vt[i].idx, vt[i].val, vt[i].cnt);
      if (i == 1) begin
        chk("row0_c0", board[0], 4);
        chk("row0_c1", board[1], 4);
        chk("row0_c3", board[3], 8);
        ok = 1;
        for (int c = 4; c < 16; c++)
          if (board[c] != '0 && board[c] != 12'd2 && board[c] != 12'd4)
            ok = 0;
        chk("spawn_value", ok, 1);
      end
      if (i == 2)
        chk("ready_after_win", mif.move_ready, 1);
    end

    for (int c = 0; c < 16; c++)
      b[c] = (((c / 4) + (c % 4)) % 2 != 0) ? 12'd4 : 12'd2;
    do_load(b);
    chk("over_set", game_over, 1);
    chk("over_ready", mif.move_ready, 0);
    d0 = done_seen;
    @(negedge clk);
    mif.move_valid = 1'b1;
    mif.move_dir   = 4'b0100;
    repeat (3) @(negedge clk);
    chk("over_dir", mm_direction, 0);
    mif.move_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("over_no_done", done_seen - d0, 0);
    chk("over_board", board[0], 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("start_over", game_over, 0);
    chk("start_tiles", nz(board), 2);
    chk("start_score", score, 0);
    chk("start_ready", mif.move_ready, 1);
    ok = 1;
    for (int c = 0; c < 16; c++)
      if (board[c] != '0 && board[c] != 12'd2 && board[c] != 12'd4)
        ok = 0;
    chk("start_values", ok, 1);

    k = '0;
    k[0] = 12'd2; k[1] = 12'd4; k[2] = 12'd8; k[3] = 12'd16;
    do_load(k);
    @(negedge clk);
    mif.move_valid = 1'b1;
    mif.move_dir   = 4'b0011;
    @(negedge clk);
    chk("bad_dir_ready", mif.move_ready, 1);
    chk("bad_dir_mmdir", mm_direction, 0);
    mif.move_valid = 1'b0;
    @(negedge clk);
    chk("bad_dir_board", board == k, 1);
    chk("bad_dir_score", score, 0);

    b = '0;
    b[0] = 12'd2; b[1] = 12'd2;
    do_load(b);
    d0 = done_seen;
    @(negedge clk);
    mif.move_valid = 1'b1;
    mif.move_dir   = 4'b0100;
    @(negedge clk);
    mif.move_valid = 1'b0;
    @(negedge clk);
    chk("spawn_phase_score", score, 4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("restart_no_done", done_seen - d0, 0);
    chk("restart_score", score, 0);
    chk("restart_tiles", nz(board), 2);

    b = '0;
    b[0] = 12'd1024; b[1] = 12'd1024;
    do_load(b);
    ovr_en    = 1'b1;
    ovr_score = 20'h80000;
    run_move(4'b0100, 4, 1'b1, 20'h80000, 1'b1, 0, 12'd2048, 2);
    run_move(4'b1000, 4, 1'b1, 20'hFFFFF, 1'b1, -1, 12'd0, 3);
    ovr_score = 20'd5;
    run_move(4'b0100, 4, 1'b1, 20'hFFFFF, 1'b1, 0, 12'd2048, -1);
    ovr_en = 1'b0;

    @(negedge clk);
    mif.move_valid = 1'b1;
    mif.move_dir   = 4'b0001;
    @(negedge clk);
    mif.move_valid = 1'b0;
    chk("move_state_dir", mm_direction, 4'b0001);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_tiles", nz(board), 0);
    chk("midrst_score", score, 0);
    chk("midrst_won", game_won, 0);
    chk("midrst_over", game_over, 0);
    chk("midrst_done", move_done, 0);
    chk("midrst_moved", moved, 0);
    chk("midrst_dir", mm_direction, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", mif.move_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
